code_loader: RTL and testbench

CODE_LOADER -- requirements
Module: code_loader

---
 rtl/unidec_pkg.sv | 25 ++
 rtl/code_table.sv | 32 +++
 rtl/code_loader.sv | 124 ++++++++++++
 tb/tb_code_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/unidec_pkg.sv
// rtl/unidec_pkg.sv - shared widths, character codes and FSM states for the code loader
package unidec_pkg;

  localparam int CHAR_W    = 3;
  localparam int WORD_W    = 13;
  localparam int MAX_CHARS = 4;
  localparam int NUM_WORDS = 8;

  localparam logic [CHAR_W-1:0] CH_A = 3'b000;
  localparam logic [CHAR_W-1:0] CH_B = 3'b001;
  localparam logic [CHAR_W-1:0] CH_C = 3'b010;
  localparam logic [CHAR_W-1:0] CH_D = 3'b011;
  localparam logic [CHAR_W-1:0] CH_E = 3'b100;

  // All-zero word has no stop bit, so it can never be a real packed code word
  localparam logic [WORD_W-1:0] INVALID_WORD = '0;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_COMMIT,
    ST_FULL,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/code_table.sv
// rtl/code_table.sv - NUM_WORDS x WORD_W register file holding committed code words
module code_table
  import unidec_pkg::*;
#(
  parameter int NUM_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [2:0]        waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [2:0]        raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [NUM_WORDS];

  // Entries return to the trap word on reset and change only on a commit write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= INVALID_WORD;
      end
    end else if (we_i && (int'(waddr_i) < NUM_WORDS)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read: a write in progress shows up only after its edge
  assign rdata_o = (int'(raddr_i) < NUM_WORDS) ? mem_q[raddr_i] : INVALID_WORD;

endmodule

// File: rtl/code_loader.sv
// rtl/code_loader.sv - packs a character stream into stop-bit code words and loads the code table
module code_loader
  import unidec_pkg::*;
#(
  parameter int NUM_WORDS = 8,
  parameter int MAX_CHARS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAR_W-1:0] in_char,
  input  logic              in_last,
  input  logic              err_clr,
  input  logic [2:0]        rd_sel,
  output logic [WORD_W-1:0] rd_word,
  output logic [3:0]        n_words,
  output logic              full,
  output logic              err
);

  localparam int CW = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;

  state_t            state_q;
  logic [WORD_W-1:0] word_q;
  logic [CW-1:0]     cnt_q;
  logic [3:0]        n_words_q;
  logic [WORD_W-1:0] commit_q;
  logic              in_ready_q;
  logic              err_q;
  logic              full_q;

  logic [3:0]        shamt_d;
  logic [WORD_W-1:0] word_d;
  logic [WORD_W-1:0] commit_d;
  logic              char_bad_d;
  logic              last_slot_d;
  logic              fills_d;

  // Partial word with the incoming character placed, and its stop-bit-terminated form
  always_comb begin
    shamt_d     = 4'(cnt_q) * 4'd3;
    word_d      = word_q | (WORD_W'(in_char) << shamt_d);
    commit_d    = word_d | (WORD_W'(1) << (shamt_d + 4'd3));
    char_bad_d  = (in_char > CH_E);
    last_slot_d = (cnt_q == CW'(MAX_CHARS - 1));
    fills_d     = ((n_words_q + 4'd1) == 4'(NUM_WORDS));
  end

  // Loader FSM; in_ready/err/full are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_COLLECT;
      word_q     <= '0;
      cnt_q      <= '0;
      n_words_q  <= '0;
      commit_q   <= '0;
      in_ready_q <= 1'b1;
      err_q      <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (in_valid) begin
            if (char_bad_d || (last_slot_d && !in_last)) begin
              state_q    <= ST_ERROR;
              word_q     <= '0;
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else if (in_last) begin
              state_q    <= ST_COMMIT;
              commit_q   <= commit_d;
              word_q     <= '0;
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
            end else begin
              word_q <= word_d;
              cnt_q  <= cnt_q + CW'(1);
            end
          end
        end
        ST_COMMIT: begin
          n_words_q <= n_words_q + 4'd1;
          if (fills_d) begin
            state_q <= ST_FULL;
            full_q  <= 1'b1;
          end else begin
            state_q    <= ST_COLLECT;
            in_ready_q <= 1'b1;
          end
        end
        ST_ERROR: begin
          if (err_clr) begin
            state_q    <= ST_COLLECT;
            in_ready_q <= 1'b1;
            err_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_FULL;
        end
      endcase
    end
  end

  code_table #(
    .NUM_WORDS(NUM_WORDS)
  ) u_table (
    .clk    (clk),
    .rst    (rst),
    .we_i   (state_q == ST_COMMIT),
    .waddr_i(n_words_q[2:0]),
    .wdata_i(commit_q),
    .raddr_i(rd_sel),
    .rdata_o(rd_word)
  );

  assign in_ready = in_ready_q;
  assign n_words  = n_words_q;
  assign full     = full_q;
  assign err      = err_q;

endmodule

// File: tb/tb_code_loader.sv
// tb/tb_code_loader.sv - randomized and directed checks of code_loader against a queue-based model
module tb_code_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_char = 3'd0;
  logic        in_last = 1'b0;
  logic        err_clr = 1'b0;
  logic [2:0]  rd_sel = 3'd0;
  logic [12:0] rd_word;
  logic [3:0]  n_words;
  logic        full;
  logic        err;

  int errors = 0;
  int checks = 0;

  // Reference model: committed words, chars of the word in progress, flags
  int m_words[$];
  int m_part[$];
  bit m_err;
  bit m_full;

  code_loader #(.NUM_WORDS(8), .MAX_CHARS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_last(in_last), .err_clr(err_clr), .rd_sel(rd_sel),
    .rd_word(rd_word), .n_words(n_words), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pack(input int ch[$]);
    int v = 0;
    for (int k = 0; k < ch.size(); k++) v += ch[k] << (3 * k);
    v += 1 << (3 * ch.size());
    return v;
  endfunction

  function automatic void model_push(input int c, input bit last);
    if (c > 4) begin
      m_err = 1; m_part.delete();
    end else if (last) begin
      m_part.push_back(c);
      m_words.push_back(pack(m_part));
      m_part.delete();
      if (m_words.size() == 8) m_full = 1;
    end else if (m_part.size() == 3) begin
      m_err = 1; m_part.delete();
    end else begin
      m_part.push_back(c);
    end
  endfunction

  // Transfers one character; returns at the negedge after the accepting edge
  task automatic push(input int c, input bit last);
    int budget = 20;
    while (!in_ready && budget > 0) begin
      @(negedge clk); budget--;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1; in_char = 3'(c); in_last = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    model_push(c, last);
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_n_words"}, 32'(n_words), 32'(m_words.size()));
    chk({tag, "_full"}, 32'(full), 32'(m_full));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(!m_err && !m_full));
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      chk($sformatf("%s_rd%0d", tag, i), 32'(rd_word),
          (i < m_words.size()) ? 32'(m_words[i]) : 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rst_async_n_words", 32'(n_words), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_words.delete(); m_part.delete(); m_err = 0; m_full = 0;
    @(negedge clk);
  endtask

  task automatic clear_err();
    err_clr = 1'b1; in_valid = 1'b1; in_char = 3'd2; in_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    m_err = 0;
  endtask

  initial begin
    int nw;
    int kind;
    int len;
    int iter;
    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_model("reset");

    // "abc": COMMIT cycle still shows old entry, new entry at t+2
    push(0, 0); push(1, 0); push(2, 1);
    rd_sel = 3'd0; #1;
    chk("abc_commit_old", 32'(rd_word), 32'd0);
    chk("abc_commit_nw", 32'(n_words), 32'd0);
    chk("abc_commit_ready", 32'(in_ready), 32'd0);
    settle();
    rd_sel = 3'd0; #1;
    chk("abc_word", 32'(rd_word), 32'(13'b0001010001000));
    check_model("abc");

    // err_clr in COLLECT has no effect
    err_clr = 1'b1; settle(); err_clr = 1'b0;
    check_model("clr_collect");

    // "e" into a fresh table
    do_reset();
    push(4, 1); settle();
    rd_sel = 3'd0; #1;
    chk("e_word", 32'(rd_word), 32'(13'b0000000001100));
    check_model("e");

    // Illegal character, then clear (in_valid ignored during clear)
    push(5, 0);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_ready", 32'(in_ready), 32'd0);
    check_model("illegal");
    clear_err();
    check_model("illegal_clr");

    // Overlong word: four chars with in_last=0
    push(0, 0); push(1, 0); push(2, 0); push(3, 0);
    chk("overlong_err", 32'(err), 32'd1);
    settle();
    check_model("overlong");
    clear_err();
    check_model("overlong_clr");

    // Reset mid-word discards everything
    push(1, 0); push(2, 0);
    do_reset();
    check_model("midreset");

    // Randomized fill with injected faults
    iter = 0;
    while (!m_full && iter < 40) begin
      iter++;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        len = $urandom_range(0, 2);
        for (int k = 0; k < len; k++) push($urandom_range(0, 4), 0);
        push($urandom_range(5, 7), 1'($urandom_range(0, 1)));
        check_model("rnd_illegal");
        clear_err();
      end else if (kind == 1) begin
        for (int k = 0; k < 4; k++) push($urandom_range(0, 4), 0);
        check_model("rnd_overlong");
        clear_err();
      end else begin
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) push($urandom_range(0, 4), k == len - 1);
        settle();
      end
      check_model("rnd");
    end
    chk("rnd_reached_full", 32'(m_full), 32'd1);

    // Fill with eight "abcd" words
    do_reset();
    for (nw = 0; nw < 8; nw++) begin
      push(0, 0); push(1, 0); push(2, 0); push(3, 1);
      settle();
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_n_words", 32'(n_words), 32'd8);
    rd_sel = 3'd7; #1;
    chk("fill_word7", 32'(rd_word), 32'(13'b1011010001000));
    check_model("fill");

    // FULL is terminal: extra input and err_clr are ignored
    in_valid = 1'b1; in_char = 3'd1; in_last = 1'b1; err_clr = 1'b1;
    for (int k = 0; k < 4; k++) settle();
    in_valid = 1'b0; in_last = 1'b0; err_clr = 1'b0;
    check_model("full_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
